// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the memory and the arbiter.
// The slave modport is the arbiter's view; the master modport is the requester and memory side.
interface mem_arbiter_if #(
   parameter int addr_width = 8,
   parameter int data_width = 8
);
   logic                  req0, write0, gnt0;
   logic [addr_width-1:0] addr0;
   logic [data_width-1:0] wdata0;
   logic                  req1, write1, gnt1;
   logic [addr_width-1:0] addr1;
   logic [data_width-1:0] wdata1;
   logic                  mem_write;
   logic [addr_width-1:0] mem_addr;
   logic [data_width-1:0] mem_wdata;
   logic [data_width-1:0] mem_rdata;
   logic [data_width-1:0] rdata;

   modport slave (
      input  req0, write0, addr0, wdata0,
      input  req1, write1, addr1, wdata1,
      input  mem_rdata,
      output gnt0, gnt1, mem_write, mem_addr, mem_wdata, rdata
   );

   modport master (
      output req0, write0, addr0, wdata0,
      output req1, write1, addr1, wdata1,
      output mem_rdata,
      input  gnt0, gnt1, mem_write, mem_addr, mem_wdata, rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: alternating tie-break, bounded bursts while the
// other port waits, grants decoded purely from the state register.
module mem_arbiter #(
   parameter int addr_width = 8,
   parameter int data_width = 8,
   parameter int max_burst  = 4
) (
   input  logic           clk,
   input  logic           rst,
   mem_arbiter_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam logic [3:0] burst_last = 4'(max_burst - 1);

   state_t                state;
   logic [3:0]            burst_cnt;
   logic                  last_owner;
   logic [addr_width-1:0] addr_mux;
   logic [data_width-1:0] wdata_mux;
   logic                  write_mux;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         burst_cnt  <= '0;
         last_owner <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               burst_cnt <= '0;
               // On a tie the port that did not own last goes next
               if (bus.req0 && (!bus.req1 || last_owner)) begin
                  state      <= OWN0;
                  last_owner <= 1'b0;
               end else if (bus.req1) begin
                  state      <= OWN1;
                  last_owner <= 1'b1;
               end
            end
            OWN0: begin
               if (!bus.req0) begin
                  burst_cnt <= '0;
                  if (bus.req1) begin
                     state      <= OWN1;
                     last_owner <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end else if (!bus.req1) begin
                  burst_cnt <= '0;
               end else if (burst_cnt >= burst_last) begin
                  state      <= OWN1;
                  last_owner <= 1'b1;
                  burst_cnt  <= '0;
               end else begin
                  burst_cnt <= burst_cnt + 4'd1;
               end
            end
            OWN1: begin
               if (!bus.req1) begin
                  burst_cnt <= '0;
                  if (bus.req0) begin
                     state      <= OWN0;
                     last_owner <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end else if (!bus.req0) begin
                  burst_cnt <= '0;
               end else if (burst_cnt >= burst_last) begin
                  state      <= OWN0;
                  last_owner <= 1'b0;
                  burst_cnt  <= '0;
               end else begin
                  burst_cnt <= burst_cnt + 4'd1;
               end
            end
            default: begin
               state     <= IDLE;
               burst_cnt <= '0;
            end
         endcase
      end
   end

   // Only the owner's fields reach memory; the other port's write is masked out
   always_comb begin
      addr_mux  = '0;
      wdata_mux = '0;
      write_mux = 1'b0;
      case (state)
         OWN0: begin
            addr_mux  = bus.addr0;
            wdata_mux = bus.wdata0;
            write_mux = bus.write0 & bus.req0;
         end
         OWN1: begin
            addr_mux  = bus.addr1;
            wdata_mux = bus.wdata1;
            write_mux = bus.write1 & bus.req1;
         end
         default: ;
      endcase
   end

   assign bus.gnt0      = (state == OWN0);
   assign bus.gnt1      = (state == OWN1);
   assign bus.mem_addr  = addr_mux;
   assign bus.mem_wdata = wdata_mux;
   assign bus.mem_write = write_mux;
   assign bus.rdata     = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences,
// then random traffic scored against an ownership-level reference model.
module tb_mem_arbiter;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int MB = 4;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.addr_width(AW), .data_width(DW)) bus ();

   mem_arbiter #(.addr_width(AW), .data_width(DW), .max_burst(MB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // owner: 0 = nobody, 1 = port 0, 2 = port 1
   typedef struct {
      logic rst, r0, r1, w0, w1;
      int   owner;
      logic mw;
   } vec_t;

   vec_t tbl[16];

   // Reference model: who owns, how long the other side has been kept waiting,
   // and who owned most recently.
   int m_owner;   // -1 none, else port index
   int m_waited;
   int m_last;

   task automatic model_step();
      logic req[2];
      int   nxt;
      req[0] = bus.req0;
      req[1] = bus.req1;
      nxt = m_owner;
      if (rst) begin
         m_owner = -1; m_waited = 0; m_last = 1;
         return;
      end
      if (m_owner < 0) begin
         if (req[0] && req[1]) nxt = 1 - m_last;
         else if (req[0])      nxt = 0;
         else if (req[1])      nxt = 1;
      end else if (!req[m_owner]) begin
         nxt = req[1 - m_owner] ? 1 - m_owner : -1;
      end else if (req[1 - m_owner]) begin
         if (m_waited + 1 >= MB) nxt = 1 - m_owner;
         else m_waited++;
      end else begin
         m_waited = 0;
      end
      if (nxt != m_owner) begin
         m_waited = 0;
         if (nxt >= 0) m_last = nxt;
      end
      m_owner = nxt;
   endtask

   task automatic check_vs_model(input string tag);
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic          ew;
      ea = '0; ed = '0; ew = 1'b0;
      if (m_owner == 0) begin ea = bus.addr0; ed = bus.wdata0; ew = bus.write0 & bus.req0; end
      if (m_owner == 1) begin ea = bus.addr1; ed = bus.wdata1; ew = bus.write1 & bus.req1; end
      chk({tag, ".gnt0"}, 32'(bus.gnt0), 32'(m_owner == 0));
      chk({tag, ".gnt1"}, 32'(bus.gnt1), 32'(m_owner == 1));
      chk({tag, ".mem_write"}, 32'(bus.mem_write), 32'(ew));
      chk({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(ea));
      chk({tag, ".mem_wdata"}, 32'(bus.mem_wdata), 32'(ed));
      chk({tag, ".rdata"}, 32'(bus.rdata), 32'(bus.mem_rdata));
   endtask

   initial begin
      rst = 1'b1;
      bus.req0 = 0; bus.write0 = 0; bus.addr0 = 8'h20; bus.wdata0 = 8'h5A;
      bus.req1 = 0; bus.write1 = 0; bus.addr1 = 8'hFF; bus.wdata1 = 8'hC3;
      bus.mem_rdata = 8'h00;

      //           rst r0 r1 w0 w1 owner mw
      tbl[0]  = '{1, 1, 1, 1, 1, 0, 0};   // reset wins over requests
      tbl[1]  = '{0, 1, 1, 1, 1, 1, 1};   // first tie goes to port 0
      tbl[2]  = '{0, 1, 1, 1, 1, 1, 1};
      tbl[3]  = '{0, 1, 1, 1, 1, 1, 1};
      tbl[4]  = '{0, 1, 1, 1, 1, 1, 1};   // 4th cycle of port 0 burst
      tbl[5]  = '{0, 1, 1, 1, 1, 2, 1};   // hand over to port 1
      tbl[6]  = '{0, 1, 1, 1, 1, 2, 1};
      tbl[7]  = '{0, 1, 1, 1, 1, 2, 1};
      tbl[8]  = '{0, 1, 1, 1, 1, 2, 1};
      tbl[9]  = '{0, 1, 1, 1, 1, 1, 1};   // back to port 0
      tbl[10] = '{0, 0, 1, 1, 1, 2, 1};   // owner drops, no idle gap
      tbl[11] = '{0, 0, 0, 1, 1, 0, 0};   // both drop -> idle, bus zeroed
      tbl[12] = '{0, 0, 1, 1, 1, 2, 1};   // port 1 alone
      tbl[13] = '{1, 1, 1, 1, 1, 0, 0};   // reset mid-ownership
      tbl[14] = '{0, 1, 1, 1, 1, 1, 1};   // port 0 first after reset
      tbl[15] = '{0, 1, 0, 0, 1, 1, 0};   // port 1 write never leaks

      repeat (2) @(posedge clk);
      #1;
      chk("reset.gnt0", 32'(bus.gnt0), 0);
      chk("reset.gnt1", 32'(bus.gnt1), 0);
      chk("reset.mem_write", 32'(bus.mem_write), 0);

      foreach (tbl[i]) begin
         @(negedge clk);
         rst = tbl[i].rst;
         bus.req0 = tbl[i].r0; bus.req1 = tbl[i].r1;
         bus.write0 = tbl[i].w0; bus.write1 = tbl[i].w1;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d.gnt0", i), 32'(bus.gnt0), 32'(tbl[i].owner == 1));
         chk($sformatf("vec%0d.gnt1", i), 32'(bus.gnt1), 32'(tbl[i].owner == 2));
         chk($sformatf("vec%0d.mem_write", i), 32'(bus.mem_write), 32'(tbl[i].mw));
         chk($sformatf("vec%0d.mem_addr", i), 32'(bus.mem_addr),
             tbl[i].owner == 1 ? 32'h20 : tbl[i].owner == 2 ? 32'hFF : 32'h0);
         chk($sformatf("vec%0d.mem_wdata", i), 32'(bus.mem_wdata),
             tbl[i].owner == 1 ? 32'h5A : tbl[i].owner == 2 ? 32'hC3 : 32'h0);
      end

      // Port 0 alone holds the memory indefinitely
      @(negedge clk);
      bus.req0 = 1; bus.req1 = 0; bus.write0 = 1; bus.mem_rdata = 8'h77;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("hold%0d.gnt0", c), 32'(bus.gnt0), 1);
         chk($sformatf("hold%0d.mem_write", c), 32'(bus.mem_write), 1);
         chk($sformatf("hold%0d.mem_addr", c), 32'(bus.mem_addr), 32'h20);
         chk($sformatf("hold%0d.mem_wdata", c), 32'(bus.mem_wdata), 32'h5A);
         chk($sformatf("hold%0d.rdata", c), 32'(bus.rdata), 32'h77);
      end

      // Port 1 raises its request mid-hold: port 0 keeps exactly MB cycles
      @(negedge clk);
      bus.req1 = 1;
      for (int c = 0; c < MB; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("burst%0d.gnt0", c), 32'(bus.gnt0), 32'(c < MB - 1));
      end
      @(posedge clk);
      #1;
      chk("burst.gnt1", 32'(bus.gnt1), 1);

      // Random traffic against the model
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      model_step();
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 3) == 0) bus.req0 = ~bus.req0;
         if ($urandom_range(0, 3) == 0) bus.req1 = ~bus.req1;
         bus.write0 = 1'($urandom);
         bus.write1 = 1'($urandom);
         bus.addr0 = 8'($urandom);
         bus.addr1 = 8'($urandom);
         bus.wdata0 = 8'($urandom);
         bus.wdata1 = 8'($urandom);
         bus.mem_rdata = 8'($urandom);
         #1;
         check_vs_model($sformatf("rnd%0d", n));
         @(posedge clk);
         model_step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
